// File: rtl/adda_pll_dyn_cfg.sv
// Run-time divider reconfiguration for the ADDA clock PLL: loads a new ratio set,
// sequences PLL reset and lock acquisition with timeout/retry, and debounces lock.
module adda_pll_dyn_cfg #(
    parameter int INIT_IDIV    = 5,
    parameter int INIT_FDIV    = 91,
    parameter int INIT_ODIV0   = 14,
    parameter int INIT_ODIV1   = 26,
    parameter int INIT_ODIV2   = 7,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 64,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int RETRY_MAX    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [9:0] cfg_idiv,
    input  logic [9:0] cfg_fdiv,
    input  logic [9:0] cfg_odiv0,
    input  logic [9:0] cfg_odiv1,
    input  logic [9:0] cfg_odiv2,
    output logic [9:0] dyn_idiv,
    output logic [9:0] dyn_fdiv,
    output logic [9:0] dyn_odiv0,
    output logic [9:0] dyn_odiv1,
    output logic [9:0] dyn_odiv2,
    output logic [9:0] dyn_duty0,
    output logic [9:0] dyn_duty1,
    output logic [9:0] dyn_duty2,
    output logic       pll_rst,
    input  logic       pll_lock,
    output logic       busy,
    output logic       locked,
    output logic       done,
    output logic       err,
    output logic       lock_lost
);

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = $clog2(LOCK_STABLE + 1);
    localparam int YW = $clog2(RETRY_MAX + 1);

    localparam logic [RW-1:0] RST_LAST   = RW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] ST_LAST    = SW'(LOCK_STABLE - 1);
    localparam logic [YW-1:0] RETRY_LAST = YW'(RETRY_MAX - 1);

    typedef enum logic [1:0] {
        RST_HOLD  = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        IDLE      = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] rst_cnt, rst_cnt_nxt;
    logic [TW-1:0] to_cnt, to_cnt_nxt;
    logic [SW-1:0] st_cnt, st_cnt_nxt;
    logic [YW-1:0] retry_cnt, retry_cnt_nxt;
    logic          lock_meta, lock_s;

    logic [9:0] idiv_nxt, fdiv_nxt, odiv0_nxt, odiv1_nxt, odiv2_nxt;
    logic       pll_rst_nxt, busy_nxt, cfg_ready_nxt, locked_nxt;
    logic       done_nxt, err_nxt, lock_lost_nxt;

    logic accept, cfg_bad, timeout;

    assign accept  = cfg_valid && cfg_ready;
    assign cfg_bad = (cfg_idiv == '0) || (cfg_fdiv == '0) || (cfg_odiv0 == '0)
                  || (cfg_odiv1 == '0) || (cfg_odiv2 == '0);
    assign timeout = (to_cnt == TO_LAST);

    // 50 % duty: the PLL duty word equals the output divider.
    assign dyn_duty0 = dyn_odiv0;
    assign dyn_duty1 = dyn_odiv1;
    assign dyn_duty2 = dyn_odiv2;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_nxt     = state;
        rst_cnt_nxt   = rst_cnt;
        to_cnt_nxt    = to_cnt;
        st_cnt_nxt    = st_cnt;
        retry_cnt_nxt = retry_cnt;
        idiv_nxt      = dyn_idiv;
        fdiv_nxt      = dyn_fdiv;
        odiv0_nxt     = dyn_odiv0;
        odiv1_nxt     = dyn_odiv1;
        odiv2_nxt     = dyn_odiv2;
        pll_rst_nxt   = pll_rst;
        busy_nxt      = busy;
        locked_nxt    = locked;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;
        lock_lost_nxt = 1'b0;

        case (state)
            RST_HOLD: begin
                pll_rst_nxt = 1'b1;
                to_cnt_nxt  = '0;
                st_cnt_nxt  = '0;
                if (rst_cnt == RST_LAST) begin
                    rst_cnt_nxt = '0;
                    pll_rst_nxt = 1'b0;
                    state_nxt   = WAIT_LOCK;
                end else begin
                    rst_cnt_nxt = rst_cnt + 1'b1;
                end
            end

            WAIT_LOCK, STABLE: begin
                if (!timeout) begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
                // A lock that completes on the timeout cycle still counts as success.
                if (state == STABLE && lock_s && st_cnt == ST_LAST) begin
                    state_nxt     = IDLE;
                    locked_nxt    = 1'b1;
                    done_nxt      = 1'b1;
                    busy_nxt      = 1'b0;
                    retry_cnt_nxt = '0;
                end else if (timeout) begin
                    if (retry_cnt == RETRY_LAST) begin
                        state_nxt     = IDLE;
                        locked_nxt    = 1'b0;
                        err_nxt       = 1'b1;
                        busy_nxt      = 1'b0;
                        retry_cnt_nxt = '0;
                    end else begin
                        retry_cnt_nxt = retry_cnt + 1'b1;
                        state_nxt     = RST_HOLD;
                        pll_rst_nxt   = 1'b1;
                        rst_cnt_nxt   = '0;
                    end
                end else if (state == WAIT_LOCK) begin
                    if (lock_s) begin
                        state_nxt  = STABLE;
                        st_cnt_nxt = '0;
                    end
                end else if (lock_s) begin
                    st_cnt_nxt = st_cnt + 1'b1;
                end else begin
                    st_cnt_nxt = '0;
                    state_nxt  = WAIT_LOCK;
                end
            end

            IDLE: begin
                if (locked && !lock_s) begin
                    lock_lost_nxt = 1'b1;
                    locked_nxt    = 1'b0;
                    state_nxt     = RST_HOLD;
                    pll_rst_nxt   = 1'b1;
                    busy_nxt      = 1'b1;
                    rst_cnt_nxt   = '0;
                end
                // A valid request overrides the relock: same sequence, new ratios.
                if (accept) begin
                    if (cfg_bad) begin
                        err_nxt = 1'b1;
                    end else begin
                        idiv_nxt    = cfg_idiv;
                        fdiv_nxt    = cfg_fdiv;
                        odiv0_nxt   = cfg_odiv0;
                        odiv1_nxt   = cfg_odiv1;
                        odiv2_nxt   = cfg_odiv2;
                        locked_nxt  = 1'b0;
                        state_nxt   = RST_HOLD;
                        pll_rst_nxt = 1'b1;
                        busy_nxt    = 1'b1;
                        rst_cnt_nxt = '0;
                    end
                end
            end

            default: begin
                state_nxt   = RST_HOLD;
                pll_rst_nxt = 1'b1;
                busy_nxt    = 1'b1;
                rst_cnt_nxt = '0;
            end
        endcase

        cfg_ready_nxt = ~busy_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RST_HOLD;
            rst_cnt   <= '0;
            to_cnt    <= '0;
            st_cnt    <= '0;
            retry_cnt <= '0;
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            dyn_idiv  <= 10'(INIT_IDIV);
            dyn_fdiv  <= 10'(INIT_FDIV);
            dyn_odiv0 <= 10'(INIT_ODIV0);
            dyn_odiv1 <= 10'(INIT_ODIV1);
            dyn_odiv2 <= 10'(INIT_ODIV2);
            pll_rst   <= 1'b1;
            busy      <= 1'b1;
            cfg_ready <= 1'b0;
            locked    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values (the synchronizer relies on it).
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
            state     <= state_nxt;
            rst_cnt   <= rst_cnt_nxt;
            to_cnt    <= to_cnt_nxt;
            st_cnt    <= st_cnt_nxt;
            retry_cnt <= retry_cnt_nxt;
            dyn_idiv  <= idiv_nxt;
            dyn_fdiv  <= fdiv_nxt;
            dyn_odiv0 <= odiv0_nxt;
            dyn_odiv1 <= odiv1_nxt;
            dyn_odiv2 <= odiv2_nxt;
            pll_rst   <= pll_rst_nxt;
            busy      <= busy_nxt;
            cfg_ready <= cfg_ready_nxt;
            locked    <= locked_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            lock_lost <= lock_lost_nxt;
        end
    end

endmodule

// File: tb/tb_adda_pll_dyn_cfg.sv
// Directed bench for adda_pll_dyn_cfg: a small PLL lock model plus hand-computed
// cycle positions for done/err/lock_lost relative to the request edge.
module tb_adda_pll_dyn_cfg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [9:0] cfg_idiv = '0, cfg_fdiv = '0, cfg_odiv0 = '0, cfg_odiv1 = '0, cfg_odiv2 = '0;
    logic [9:0] dyn_idiv, dyn_fdiv, dyn_odiv0, dyn_odiv1, dyn_odiv2;
    logic [9:0] dyn_duty0, dyn_duty1, dyn_duty2;
    logic       pll_rst, pll_lock, busy, locked, done, err, lock_lost;

    int n_cmp = 0;
    int n_bad = 0;

    // PLL model: lock rises lock_delay cycles after pll_rst falls; tie_high/kill override.
    logic tie_high = 1'b1;
    logic kill = 1'b0;
    logic model_lock = 1'b0;
    int   lock_delay = 200;
    int   mcnt = 0;

    assign pll_lock = ~kill & (tie_high | model_lock);

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (pll_rst) begin
            mcnt = 0;
            model_lock = 1'b0;
        end else begin
            if (mcnt < lock_delay) mcnt++;
            if (mcnt >= lock_delay) model_lock = 1'b1;
        end
    end

    adda_pll_dyn_cfg #(.LOCK_TIMEOUT(1000)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_idiv(cfg_idiv), .cfg_fdiv(cfg_fdiv),
        .cfg_odiv0(cfg_odiv0), .cfg_odiv1(cfg_odiv1), .cfg_odiv2(cfg_odiv2),
        .dyn_idiv(dyn_idiv), .dyn_fdiv(dyn_fdiv),
        .dyn_odiv0(dyn_odiv0), .dyn_odiv1(dyn_odiv1), .dyn_odiv2(dyn_odiv2),
        .dyn_duty0(dyn_duty0), .dyn_duty1(dyn_duty1), .dyn_duty2(dyn_duty2),
        .pll_rst(pll_rst), .pll_lock(pll_lock),
        .busy(busy), .locked(locked), .done(done), .err(err), .lock_lost(lock_lost)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present a request at a negedge; returns at the negedge after the accept edge.
    task automatic send_req(input logic [9:0] i, input logic [9:0] f,
                            input logic [9:0] o0, input logic [9:0] o1, input logic [9:0] o2);
        cfg_idiv  = i;
        cfg_fdiv  = f;
        cfg_odiv0 = o0;
        cfg_odiv1 = o1;
        cfg_odiv2 = o2;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Observe w cycles; index i is the negedge after the i-th edge from now.
    task automatic watch(input int w, input int kill_on, input int kill_off,
                         output int first_done, output int n_done,
                         output int first_ll, output int n_ll, output int n_err);
        first_done = -1; n_done = 0; first_ll = -1; n_ll = 0; n_err = 0;
        for (int i = 0; i <= w; i++) begin
            if (i > 0) @(negedge clk);
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = i;
            end
            if (lock_lost) begin
                n_ll++;
                if (first_ll < 0) first_ll = i;
            end
            if (err) n_err++;
            if (i == kill_on) kill = 1'b1;
            if (i == kill_off) kill = 1'b0;
        end
    endtask

    // Release rst at a negedge and check the power-on lock sequence (pll_lock high).
    task automatic power_on(input string tag);
        int n;
        int first;
        int pulses;
        rst = 1'b0;
        n = 0;
        while (pll_rst && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_rst_high_cycles"}, n, 16);
        first = -1;
        pulses = 0;
        for (int p = n + 1; p <= 200; p++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                if (first < 0) first = p;
            end
        end
        // 16 reset cycles, 1 cycle to see lock_s in WAIT_LOCK, 64 stable cycles
        check({tag, "_done_cycle"}, first, 81);
        check({tag, "_done_pulses"}, pulses, 1);
        check({tag, "_locked"}, locked, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cfg_ready"}, cfg_ready, 1);
    endtask

    initial begin
        int fd, nd, fl, nl, ne;
        int rises, rise1, rise2, first_err, n_err_t;
        logic prev;

        repeat (3) @(negedge clk);
        check("rst_pll_rst", pll_rst, 1);
        check("rst_busy", busy, 1);
        check("rst_cfg_ready", cfg_ready, 0);
        check("rst_locked", locked, 0);
        check("rst_pulses", {done, err, lock_lost}, 0);
        check("rst_idiv", dyn_idiv, 5);
        check("rst_fdiv", dyn_fdiv, 91);
        check("rst_odiv0", dyn_odiv0, 14);
        check("rst_odiv1", dyn_odiv1, 26);
        check("rst_odiv2", dyn_odiv2, 7);
        check("rst_duty0", dyn_duty0, 14);

        power_on("por");

        // Hand pll_lock over to the model once its lock has come up.
        repeat (250) @(negedge clk);
        tie_high = 1'b0;
        nl = 0;
        repeat (10) begin
            @(negedge clk);
            if (lock_lost) nl++;
        end
        check("handover_lock_lost", nl, 0);
        check("handover_locked", locked, 1);

        // Reconfigure; model lock returns 200 cycles after pll_rst falls.
        send_req(10'd4, 10'd80, 10'd10, 10'd20, 10'd5);
        check("cfg_idiv", dyn_idiv, 4);
        check("cfg_fdiv", dyn_fdiv, 80);
        check("cfg_odiv0", dyn_odiv0, 10);
        check("cfg_odiv1", dyn_odiv1, 20);
        check("cfg_odiv2", dyn_odiv2, 5);
        check("cfg_duty", {dyn_duty0, dyn_duty1, dyn_duty2}, {10'd10, 10'd20, 10'd5});
        check("cfg_pll_rst", pll_rst, 1);
        check("cfg_busy_ready", {busy, cfg_ready}, 2'b10);
        check("cfg_locked", locked, 0);
        watch(350, -1, -1, fd, nd, fl, nl, ne);
        // lock at +215, lock_s +217, STABLE +218, done +282
        check("cfg_done_cycle", fd, 282);
        check("cfg_done_pulses", nd, 1);
        check("cfg_err_pulses", ne, 0);
        check("cfg_locked_after", locked, 1);

        // Reject: a zero field.
        send_req(10'd7, 10'd0, 10'd9, 10'd9, 10'd9);
        check("rej_err", err, 1);
        check("rej_cfg_ready", cfg_ready, 1);
        check("rej_fdiv", dyn_fdiv, 80);
        check("rej_idiv", dyn_idiv, 4);
        check("rej_pll_rst", pll_rst, 0);
        check("rej_locked", locked, 1);
        @(negedge clk);
        check("rej_err_one_cycle", err, 0);
        check("rej_locked_after", {locked, pll_rst, busy}, 3'b100);

        // One-cycle glitch at stable count 40 restarts the stable count.
        lock_delay = 20;
        send_req(10'd2, 10'd50, 10'd8, 10'd16, 10'd4);
        watch(200, 78, 79, fd, nd, fl, nl, ne);
        check("sglitch_done_cycle", fd, 146);
        check("sglitch_done_pulses", nd, 1);
        check("sglitch_lock_lost", nl, 0);
        check("sglitch_odiv1", dyn_odiv1, 16);
        check("sglitch_locked", locked, 1);

        // Five-cycle lock drop in IDLE: lock_lost then automatic relock.
        watch(150, 0, 5, fd, nd, fl, nl, ne);
        check("iglitch_ll_cycle", fl, 3);
        check("iglitch_ll_pulses", nl, 1);
        check("iglitch_done_cycle", fd, 105);
        check("iglitch_done_pulses", nd, 1);
        check("iglitch_locked", locked, 1);
        check("iglitch_ratios", {dyn_idiv, dyn_fdiv}, {10'd2, 10'd50});

        // Lock stuck low: three reset attempts, then err.
        kill = 1'b1;
        send_req(10'd3, 10'd60, 10'd6, 10'd12, 10'd3);
        rises = 0; rise1 = -1; rise2 = -1; first_err = -1; n_err_t = 0; nd = 0;
        prev = 1'b0;
        for (int i = 0; i <= 3100; i++) begin
            if (i > 0) @(negedge clk);
            if (pll_rst && !prev) begin
                rises++;
                if (rises == 2) rise1 = i;
                if (rises == 3) rise2 = i;
            end
            prev = pll_rst;
            if (err) begin
                n_err_t++;
                if (first_err < 0) first_err = i;
            end
            if (done) nd++;
        end
        check("to_rst_pulses", rises, 3);
        check("to_second_pulse", rise1, 1016);
        check("to_third_pulse", rise2, 2032);
        check("to_err_cycle", first_err, 3048);
        check("to_err_pulses", n_err_t, 1);
        check("to_done_pulses", nd, 0);
        check("to_final", {locked, cfg_ready, busy, pll_rst}, 4'b0100);

        // Asynchronous reset during WAIT_LOCK.
        kill = 1'b0;
        send_req(10'd4, 10'd80, 10'd10, 10'd20, 10'd5);
        repeat (20) @(negedge clk);
        check("mid_pre_pll_rst", pll_rst, 0);
        check("mid_pre_busy_idiv", {busy, dyn_idiv}, {1'b1, 10'd4});
        #3 rst = 1'b1;
        #1;
        check("mid_async_pll_rst", pll_rst, 1);
        check("mid_async_idiv", dyn_idiv, 5);
        check("mid_async_fdiv", dyn_fdiv, 91);
        check("mid_async_odiv", {dyn_odiv0, dyn_odiv1, dyn_odiv2}, {10'd14, 10'd26, 10'd7});
        check("mid_async_state", {locked, busy}, 2'b01);
        tie_high = 1'b1;
        @(negedge clk);
        power_on("mid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
